// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 control sequencer.
//   - opcode constants (IR[15:12])
//   - ALU function codes and datapath mux select encodings
//   - sequencer state enum and the packed control word driven to the datapath
package mu0_pkg;

   localparam int FS_W = 2;   // ALU function select width
   localparam int OP_W = 4;   // opcode field width

   localparam logic [OP_W-1:0] OP_LDA = 4'd0;
   localparam logic [OP_W-1:0] OP_STA = 4'd1;
   localparam logic [OP_W-1:0] OP_ADD = 4'd2;
   localparam logic [OP_W-1:0] OP_SUB = 4'd3;
   localparam logic [OP_W-1:0] OP_JMP = 4'd4;
   localparam logic [OP_W-1:0] OP_JGE = 4'd5;
   localparam logic [OP_W-1:0] OP_JNE = 4'd6;
   localparam logic [OP_W-1:0] OP_STP = 4'd7;

   localparam logic [FS_W-1:0] FS_ADD   = 2'd0;  // X+Y
   localparam logic [FS_W-1:0] FS_SUB   = 2'd1;  // X-Y
   localparam logic [FS_W-1:0] FS_INC   = 2'd2;  // X+1
   localparam logic [FS_W-1:0] FS_PASSB = 2'd3;  // Y

   localparam logic SEL_ACC = 1'b0;  // X_sel / Addr_sel source = ACC / PC
   localparam logic SEL_PC  = 1'b1;
   localparam logic SEL_MEM = 1'b0;  // Y_sel source = memory data
   localparam logic SEL_IMM = 1'b1;  // Y_sel source = IR[11:0]

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      EXECUTE = 2'd1,
      HALT    = 2'd2
   } state_t;

   typedef struct packed {
      logic            ir_en;
      logic            pc_en;
      logic            acc_en;
      logic            x_sel;
      logic            y_sel;
      logic            addr_sel;
      logic [FS_W-1:0] alu_fs;
      logic            mem_rd;
      logic            mem_wr;
      logic            halted;
   } ctrl_t;

   // Memory opcodes wait on MemRdy; everything else executes in one cycle.
   function automatic logic is_mem_op(input logic [OP_W-1:0] f);
      return (f == OP_LDA) || (f == OP_STA) || (f == OP_ADD) || (f == OP_SUB);
   endfunction

endpackage

// File: rtl/mu0_ctrl_decode.sv
// Combinational output decode for the MU0 sequencer.
// Ports:
//   state  - current sequencer state
//   F      - opcode from IR[15:12]
//   N, Z   - ACC negative / zero flags, used directly in the EXECUTE cycle
//   MemRdy - memory completed the current access this cycle
//   ctrl   - datapath enables, selects, ALU function and memory strobes
module mu0_ctrl_decode
   import mu0_pkg::*;
(
   input  state_t          state,
   input  logic [OP_W-1:0] F,
   input  logic            N,
   input  logic            Z,
   input  logic            MemRdy,
   output ctrl_t           ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         FETCH: begin
            // Read instruction at PC while the ALU forms PC+1; both land
            // only once memory returns the word.
            ctrl.addr_sel = SEL_ACC;
            ctrl.mem_rd   = 1'b1;
            ctrl.x_sel    = SEL_PC;
            ctrl.alu_fs   = FS_INC;
            ctrl.ir_en    = MemRdy;
            ctrl.pc_en    = MemRdy;
         end
         EXECUTE: begin
            case (F)
               OP_LDA: begin
                  ctrl.addr_sel = SEL_PC;
                  ctrl.mem_rd   = 1'b1;
                  ctrl.y_sel    = SEL_MEM;
                  ctrl.alu_fs   = FS_PASSB;
                  ctrl.acc_en   = MemRdy;
               end
               OP_STA: begin
                  ctrl.addr_sel = SEL_PC;
                  ctrl.mem_wr   = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  ctrl.addr_sel = SEL_PC;
                  ctrl.mem_rd   = 1'b1;
                  ctrl.x_sel    = SEL_ACC;
                  ctrl.y_sel    = SEL_MEM;
                  ctrl.alu_fs   = (F == OP_SUB) ? FS_SUB : FS_ADD;
                  ctrl.acc_en   = MemRdy;
               end
               OP_JMP, OP_JGE, OP_JNE: begin
                  ctrl.y_sel  = SEL_IMM;
                  ctrl.alu_fs = FS_PASSB;
                  ctrl.pc_en  = (F == OP_JMP) ? 1'b1 :
                                (F == OP_JGE) ? ~N : ~Z;
               end
               default: ;  // STP and 8-15: no enables, no strobes
            endcase
         end
         HALT: ctrl.halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/mu0_control.sv
// MU0 fetch/execute control sequencer.
// Ports:
//   Clk, Reset        - rising-edge clock, asynchronous active-high reset
//   F, N, Z           - opcode and ACC flags
//   MemRdy            - memory access completion
//   IR_En/PC_En/Acc_En- datapath register loads
//   X_sel/Y_sel/Addr_sel/ALU_fs - datapath steering
//   Mem_Rd/Mem_Wr     - memory strobes; Halted - CPU stopped
//
// Memory handshake: a strobe (Mem_Rd or Mem_Wr) together with its address
// select is held steady from the first cycle of an access until the cycle in
// which MemRdy=1; that cycle completes the access, the dependent register
// enable fires in that same cycle, and the FSM advances on the next edge.
module mu0_control
   import mu0_pkg::*;
(
   input  logic            Clk,
   input  logic            Reset,
   input  logic [OP_W-1:0] F,
   input  logic            N,
   input  logic            Z,
   input  logic            MemRdy,
   output logic            IR_En,
   output logic            PC_En,
   output logic            Acc_En,
   output logic            X_sel,
   output logic            Y_sel,
   output logic            Addr_sel,
   output logic [FS_W-1:0] ALU_fs,
   output logic            Mem_Rd,
   output logic            Mem_Wr,
   output logic            Halted
);

   state_t state, state_next;
   ctrl_t  dec_ctrl, ctrl;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= FETCH;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         FETCH:   if (MemRdy) state_next = EXECUTE;
         EXECUTE: begin
            if (is_mem_op(F))   state_next = MemRdy ? FETCH : EXECUTE;
            else if (F == OP_STP) state_next = HALT;
            else                state_next = FETCH;
         end
         HALT:    state_next = HALT;
         default: state_next = FETCH;
      endcase
   end

   mu0_ctrl_decode u_decode (
      .state  (state),
      .F      (F),
      .N      (N),
      .Z      (Z),
      .MemRdy (MemRdy),
      .ctrl   (dec_ctrl)
   );

   // The state register already reads FETCH while Reset is high, which would
   // raise Mem_Rd; gate everything so reset is fully quiet.
   assign ctrl = Reset ? '0 : dec_ctrl;

   assign IR_En    = ctrl.ir_en;
   assign PC_En    = ctrl.pc_en;
   assign Acc_En   = ctrl.acc_en;
   assign X_sel    = ctrl.x_sel;
   assign Y_sel    = ctrl.y_sel;
   assign Addr_sel = ctrl.addr_sel;
   assign ALU_fs   = ctrl.alu_fs;
   assign Mem_Rd   = ctrl.mem_rd;
   assign Mem_Wr   = ctrl.mem_wr;
   assign Halted   = ctrl.halted;

endmodule

// File: tb/tb_mu0_control.sv
// Directed bench for mu0_control. Inputs change 1 time unit after a rising
// edge; outputs are checked 2 units later, well clear of either edge.
// Output word order: {IR_En,PC_En,Acc_En,X_sel,Y_sel,Addr_sel,ALU_fs,Mem_Rd,Mem_Wr,Halted}
module tb_mu0_control;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [3:0] F;
   logic       N, Z, MemRdy;
   logic       IR_En, PC_En, Acc_En, X_sel, Y_sel, Addr_sel;
   logic [1:0] ALU_fs;
   logic       Mem_Rd, Mem_Wr, Halted;

   int checks = 0;
   int errors = 0;

   mu0_control dut (
      .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .MemRdy(MemRdy),
      .IR_En(IR_En), .PC_En(PC_En), .Acc_En(Acc_En), .X_sel(X_sel),
      .Y_sel(Y_sel), .Addr_sel(Addr_sel), .ALU_fs(ALU_fs),
      .Mem_Rd(Mem_Rd), .Mem_Wr(Mem_Wr), .Halted(Halted)
   );

   // clock
   always #5 Clk = ~Clk;

   function automatic logic [10:0] mk(input logic ir, pc, acc, xs, ys, as,
                                      input logic [1:0] fs,
                                      input logic rd, wr, h);
      return {ir, pc, acc, xs, ys, as, fs, rd, wr, h};
   endfunction

   // hand-derived expected control words
   logic [10:0] E_ZERO, E_FETCH_RDY, E_FETCH_WAIT, E_LDA_RDY, E_LDA_WAIT,
                E_STA, E_ADD_RDY, E_ADD_WAIT, E_SUB_RDY, E_JMP_T, E_JMP_NT, E_HALT;

   initial begin
      E_ZERO       = '0;
      E_FETCH_RDY  = mk(1,1,0,1,0,0,2'd2,1,0,0);
      E_FETCH_WAIT = mk(0,0,0,1,0,0,2'd2,1,0,0);
      E_LDA_RDY    = mk(0,0,1,0,0,1,2'd3,1,0,0);
      E_LDA_WAIT   = mk(0,0,0,0,0,1,2'd3,1,0,0);
      E_STA        = mk(0,0,0,0,0,1,2'd0,0,1,0);
      E_ADD_RDY    = mk(0,0,1,0,0,1,2'd0,1,0,0);
      E_ADD_WAIT   = mk(0,0,0,0,0,1,2'd0,1,0,0);
      E_SUB_RDY    = mk(0,0,1,0,0,1,2'd1,1,0,0);
      E_JMP_T      = mk(0,1,0,0,1,0,2'd3,0,0,0);
      E_JMP_NT     = mk(0,0,0,0,1,0,2'd3,0,0,0);
      E_HALT       = mk(0,0,0,0,0,0,2'd0,0,0,1);
   end

   // driver tasks
   task automatic drive(input logic [3:0] f, input logic n, z, rdy);
      F = f; N = n; Z = z; MemRdy = rdy;
      #2;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // checker
   task automatic check(input string tag, input logic [10:0] exp);
      logic [10:0] obs;
      obs = {IR_En, PC_En, Acc_En, X_sel, Y_sel, Addr_sel, ALU_fs, Mem_Rd, Mem_Wr, Halted};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %b expected %b", tag, obs, exp);
      end
      checks++;
      assert (!(Mem_Rd === 1'b1 && Mem_Wr === 1'b1)) else begin
         errors++;
         $error("FAIL %s_rdwr_excl: got rd=%b wr=%b expected not both 1", tag, Mem_Rd, Mem_Wr);
      end
   endtask

   initial begin
      // reset
      Reset = 1'b1; F = 4'd0; N = 1'b0; Z = 1'b0; MemRdy = 1'b0;
      tick(); tick();
      drive(4'd0, 0, 0, 0);
      check("reset_quiet", E_ZERO);
      Reset = 1'b0;
      drive(4'd0, 0, 0, 0);
      check("fetch_after_reset", E_FETCH_WAIT);

      // LDA, memory ready throughout
      drive(4'd0, 0, 0, 1); check("lda_fetch", E_FETCH_RDY);
      tick(); drive(4'd0, 0, 0, 1); check("lda_exec", E_LDA_RDY);
      tick(); drive(4'd2, 0, 0, 1); check("lda_back_fetch", E_FETCH_RDY);

      // ADD with three wait cycles in EXECUTE
      tick(); drive(4'd2, 0, 0, 0); check("add_wait1", E_ADD_WAIT);
      tick(); drive(4'd2, 0, 0, 0); check("add_wait2", E_ADD_WAIT);
      tick(); drive(4'd2, 0, 0, 0); check("add_wait3", E_ADD_WAIT);
      tick(); drive(4'd2, 0, 0, 1); check("add_done", E_ADD_RDY);
      tick(); drive(4'd1, 0, 0, 1); check("add_back_fetch", E_FETCH_RDY);

      // STA: one wait, then completes
      tick(); drive(4'd1, 0, 0, 0); check("sta_wait", E_STA);
      tick(); drive(4'd1, 0, 0, 1); check("sta_done", E_STA);
      tick(); drive(4'd3, 0, 0, 1); check("sta_back_fetch", E_FETCH_RDY);

      // SUB
      tick(); drive(4'd3, 0, 0, 1); check("sub_exec", E_SUB_RDY);
      tick(); drive(4'd5, 1, 0, 1); check("jge_fetch", E_FETCH_RDY);

      // JGE with N=1 not taken, MemRdy low yet still one cycle
      tick(); drive(4'd5, 1, 0, 0); check("jge_n1", E_JMP_NT);
      tick(); drive(4'd5, 0, 0, 0); check("fetch_wait", E_FETCH_WAIT);
      drive(4'd5, 0, 0, 1);         check("jge_fetch2", E_FETCH_RDY);
      tick(); drive(4'd5, 0, 0, 0); check("jge_n0", E_JMP_T);
      tick(); drive(4'd6, 0, 1, 1); check("jne_fetch", E_FETCH_RDY);
      tick(); drive(4'd6, 0, 1, 0); check("jne_z1", E_JMP_NT);
      tick(); drive(4'd6, 0, 0, 1); check("jne_fetch2", E_FETCH_RDY);
      tick(); drive(4'd6, 0, 0, 0); check("jne_z0", E_JMP_T);
      tick(); drive(4'd4, 1, 1, 1); check("jmp_fetch", E_FETCH_RDY);
      tick(); drive(4'd4, 1, 1, 0); check("jmp_exec", E_JMP_T);

      // NOP opcodes 9 and 15
      tick(); drive(4'd9, 0, 0, 1); check("nop9_fetch", E_FETCH_RDY);
      tick(); drive(4'd9, 0, 0, 0); check("nop9_exec", E_ZERO);
      tick(); drive(4'd15, 1, 1, 1); check("nop9_back_fetch", E_FETCH_RDY);
      tick(); drive(4'd15, 1, 1, 1); check("nop15_exec", E_ZERO);
      tick(); drive(4'd0, 0, 0, 1); check("nop15_back_fetch", E_FETCH_RDY);

      // Reset in the middle of an LDA wait
      tick(); drive(4'd0, 0, 0, 0); check("lda_wait", E_LDA_WAIT);
      Reset = 1'b1;
      #1; check("reset_mid_lda", E_ZERO);
      tick(); drive(4'd0, 0, 0, 1); check("reset_held", E_ZERO);
      Reset = 1'b0;
      drive(4'd0, 0, 0, 0); check("fetch_after_mid_reset", E_FETCH_WAIT);

      // STP then halt for 20 cycles regardless of inputs
      drive(4'd7, 0, 0, 1); check("stp_fetch", E_FETCH_RDY);
      tick(); drive(4'd7, 0, 0, 1); check("stp_exec", E_ZERO);
      for (int i = 0; i < 20; i++) begin
         tick();
         drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         check("halted", E_HALT);
      end
      Reset = 1'b1;
      #1; check("reset_clears_halt", E_ZERO);
      tick(); Reset = 1'b0;
      drive(4'd0, 0, 0, 1); check("fetch_after_halt", E_FETCH_RDY);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
